johnson_seq_monitor: RTL and testbench
======================================

# johnson_seq_monitor

Downstream checker for the 4-bit synchronous sequence counter, which steps through the 8-state twisted-ring code 0000→0001→0011→0111→1111→1110→1100→1000→0000. The block samples the counter's `q` bus every enabled clock. It decodes the code to a 3-bit phase index, checks each step against the legal successor, and acquires and holds lock. It also reports sequence errors and completed cycles to the rest of the lab design.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: consecutive legal advances required to move from ACQUIRE to LOCKED; legal range 1..15.
- `ERR_W`, default 8: width of the saturating error counter.
- `CYC_W`, default 8: width of the wrapping cycle counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous and active-high; takes priority over every other input.
- `q_in`  in  4  counter output bus (bit 3 = MSB).
- `in_valid`  in  1  sample qualifier; when low, `q_in` is ignored.
- `phase`  out  3  index of the last legal code sampled (0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7).
- `phase_valid`  out  1  the last sampled code was legal.
- `locked`  out  1  state is LOCKED.
- `seq_error`  out  1  one-cycle pulse on a detected error.
- `wrap`  out  1  one-cycle pulse on a locked 7→0 advance.
- `err_count`  out  ERR_W  saturating count of `seq_error` pulses.
- `cycle_count`  out  CYC_W  count of `wrap` pulses, wrapping modulo 2^CYC_W.

## Operation
- Decode: the 8 codes listed under `phase` are legal. The other 8 codes (0010, 0100, 0101, 0110, 1001, 1010, 1011, 1101) are illegal.
- Classification of each valid sample against the stored previous index `prev`:
  - SUCC: legal code and idx = (prev+1) mod 8.
  - HOLD: legal code and idx = prev.
  - BADSTEP: legal code, any other idx.
  - ILLEGAL: illegal code.
- States: UNLOCKED, ACQUIRE, LOCKED. Internal counter `lock_cnt` is 4 bits.
- UNLOCKED:
  - Legal code → ACQUIRE; `prev`=idx; `lock_cnt`=0.
  - ILLEGAL → stay in UNLOCKED; no `seq_error`.
- ACQUIRE:
  - SUCC → `lock_cnt`+1. If the new value equals `LOCK_COUNT` → LOCKED.
  - HOLD → no change.
  - BADSTEP → stay in ACQUIRE; `lock_cnt`=0; `seq_error`.
  - ILLEGAL → UNLOCKED; `seq_error`.
- LOCKED:
  - SUCC → stay locked. `wrap` pulses if prev=7 and idx=0.
  - HOLD → stay locked.
  - BADSTEP → ACQUIRE; `lock_cnt`=0; `seq_error`.
  - ILLEGAL → UNLOCKED; `seq_error`.
- `prev` and `phase` update on every valid legal code. Both hold on ILLEGAL.
- `phase_valid` updates on every valid sample: 1 for a legal code, 0 for an illegal one.
- `err_count` increments with each `seq_error` and saturates at all-ones.
- `cycle_count` increments with each `wrap` and wraps to 0.
- `in_valid` low: state, `prev`, `phase`, `phase_valid` and both counters hold; `seq_error`=0 and `wrap`=0.

## Timing
- All outputs are registered. Latency is 1 cycle: the effect of the sample taken at edge N is visible after edge N.
- Reset values: `phase`=0, `phase_valid`=0, `locked`=0, `seq_error`=0, `wrap`=0, `err_count`=0, `cycle_count`=0. State resets to UNLOCKED, `prev`=0, `lock_cnt`=0.
- `clear` asserted mid-operation returns everything to reset values at the next edge, regardless of `in_valid`.
- Lock latency with a clean stream and `LOCK_COUNT`=L: `locked` rises after the (L+1)th valid sample.
- `seq_error` and `wrap` are never asserted in the same cycle. Each pulse is high for exactly one cycle per triggering sample.
- Consecutive valid samples are allowed every cycle; there is no back-pressure.

## Structure
- Package `johnson_seq_pkg` holds:
  - the state encoding (UNLOCKED=0, ACQUIRE=1, LOCKED=2);
  - the constant `NUM_PHASES`=8;
  - the 8 legal code constants in phase order.
- Sub-module `johnson_decode` is combinational. Its ports are `code[3:0]` in, `idx[2:0]` out and `legal` out. The top level instantiates it once, on `q_in`.
- The top level contains the classifier, the FSM, `lock_cnt`, the counters and the output registers.

## Test plan
- Clean stream from reset (`in_valid`=1 every cycle, L=4): codes 0,1,3,7,15 → `locked`=1 after the 5th sample. Continuing 14,12,8,0 → `wrap`=1 on the 0 sample, then `cycle_count`=1, `err_count`=0.
- While locked, inject 0101 → `seq_error` pulse, UNLOCKED, `phase_valid`=0, `phase` holds its prior value, `err_count`=1. The next legal code → ACQUIRE.
- While locked at phase 3 (0111), present 1100 → `seq_error`, `locked`=0, `phase`=6. Four further successors (8,0,1,3) → relocked.
- Holds and gaps: repeat 0011 three times, with `in_valid` low for 2 cycles in between → no error, `lock_cnt` unchanged, `phase`=2 throughout.
- Saturation: with ERR_W=2, force 5 BADSTEPs → `err_count` stops at 3. With CYC_W=2, run 5 locked cycles → `cycle_count`=1.
- Assert `clear` for one cycle while locked, with `in_valid`=1 → all outputs at reset values on the next cycle. Relock takes the full L+1 samples.

Source files
------------

// File: rtl/johnson_seq_pkg.sv
// ---------------------------------------------------------------------------
// johnson_seq_pkg
//
// Shared definitions for the twisted-ring (Johnson) sequence monitor.
//
// Contents:
//   - NUM_PHASES, PHASE_W, CODE_W : size constants of the 8-state ring
//   - phase_t, code_t             : convenience vector types
//   - seq_state_t                 : monitor FSM state encoding
//   - step_class_t                : classification of one valid sample
//   - CODE_P0 .. CODE_P7          : the eight legal codes in phase order
//   - next_phase()                : successor of a phase index, modulo 8
//   - classify_step()             : SUCC / HOLD / BADSTEP / ILLEGAL decision
// ---------------------------------------------------------------------------
package johnson_seq_pkg;

  localparam int NUM_PHASES = 8;
  localparam int PHASE_W    = 3;
  localparam int CODE_W     = 4;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [CODE_W-1:0]  code_t;

  // Monitor FSM state. Encoding is fixed so the state can be probed directly.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } seq_state_t;

  // How one valid sample relates to the previously stored phase.
  typedef enum logic [1:0] {
    CL_SUCC    = 2'd0,
    CL_HOLD    = 2'd1,
    CL_BADSTEP = 2'd2,
    CL_ILLEGAL = 2'd3
  } step_class_t;

  // Legal ring codes, listed in phase order 0..7.
  localparam code_t CODE_P0 = 4'b0000;
  localparam code_t CODE_P1 = 4'b0001;
  localparam code_t CODE_P2 = 4'b0011;
  localparam code_t CODE_P3 = 4'b0111;
  localparam code_t CODE_P4 = 4'b1111;
  localparam code_t CODE_P5 = 4'b1110;
  localparam code_t CODE_P6 = 4'b1100;
  localparam code_t CODE_P7 = 4'b1000;

  // Successor index on the ring; phase 7 advances back to phase 0.
  function automatic phase_t next_phase(input phase_t p);
    return phase_t'((int'(p) + 1) % NUM_PHASES);
  endfunction

  // Classify a decoded sample against the stored previous index.
  function automatic step_class_t classify_step(input logic   legal,
                                                input phase_t idx,
                                                input phase_t prev);
    step_class_t cls;
    if (!legal) begin
      cls = CL_ILLEGAL;
    end else if (idx == next_phase(prev)) begin
      cls = CL_SUCC;
    end else if (idx == prev) begin
      cls = CL_HOLD;
    end else begin
      cls = CL_BADSTEP;
    end
    return cls;
  endfunction

endpackage : johnson_seq_pkg

// File: rtl/johnson_decode.sv
// ---------------------------------------------------------------------------
// johnson_decode
//
// Purely combinational decoder from a 4-bit twisted-ring code to its phase
// index. Eight of the sixteen code points are legal; the other eight flag
// legal=0 and report idx=0 (the value is meaningless when legal is low).
//
// Ports:
//   code  in  4  sampled counter bus (bit 3 = MSB)
//   idx   out 3  phase index 0..7 of a legal code
//   legal out 1  code is one of the eight ring states
// ---------------------------------------------------------------------------
module johnson_decode
  import johnson_seq_pkg::*;
(
  input  logic [3:0] code,
  output logic [2:0] idx,
  output logic       legal
);

  always_comb begin
    // NOTE: defaults first so every path through the case drives both
    // outputs; without them the unlisted codes would infer latches.
    idx   = 3'd0;
    legal = 1'b0;
    case (code)
      CODE_P0: begin idx = 3'd0; legal = 1'b1; end
      CODE_P1: begin idx = 3'd1; legal = 1'b1; end
      CODE_P2: begin idx = 3'd2; legal = 1'b1; end
      CODE_P3: begin idx = 3'd3; legal = 1'b1; end
      CODE_P4: begin idx = 3'd4; legal = 1'b1; end
      CODE_P5: begin idx = 3'd5; legal = 1'b1; end
      CODE_P6: begin idx = 3'd6; legal = 1'b1; end
      CODE_P7: begin idx = 3'd7; legal = 1'b1; end
      default: begin idx = 3'd0; legal = 1'b0; end
    endcase
  end

endmodule : johnson_decode

// File: rtl/johnson_seq_monitor.sv
// ---------------------------------------------------------------------------
// johnson_seq_monitor
//
// Watches the 4-bit twisted-ring counter bus, decodes each qualified sample
// to a phase index, checks it against the legal successor of the previous
// sample and maintains an UNLOCKED / ACQUIRE / LOCKED lock state. Sequence
// errors and completed ring cycles are reported as one-cycle pulses and
// accumulated in a saturating error counter and a wrapping cycle counter.
//
// Parameters:
//   LOCK_COUNT  consecutive successors needed in ACQUIRE to lock (1..15)
//   ERR_W       width of the saturating error counter
//   CYC_W       width of the wrapping cycle counter
//
// Ports:
//   clock        in  1      rising-edge clock
//   clear        in  1      synchronous active-high reset, highest priority
//   q_in         in  4      counter bus
//   in_valid     in  1      sample qualifier
//   phase        out 3      index of the last legal sample
//   phase_valid  out 1      last valid sample was a legal code
//   locked       out 1      monitor is in LOCKED
//   seq_error    out 1      one-cycle pulse on a detected sequence error
//   wrap         out 1      one-cycle pulse on a locked 7->0 advance
//   err_count    out ERR_W  saturating count of seq_error pulses
//   cycle_count  out CYC_W  wrapping count of wrap pulses
//
// All outputs are registered; a sample taken at edge N is reflected in the
// outputs right after edge N.
// ---------------------------------------------------------------------------
module johnson_seq_monitor
  import johnson_seq_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  parameter int CYC_W      = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [3:0]       q_in,
  input  logic             in_valid,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             seq_error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] cycle_count
);

  // lock_cnt is four bits wide, so only LOCK_COUNT values 1..15 are reachable.
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  // -------------------------------------------------------------------------
  // Decode and classification
  // -------------------------------------------------------------------------
  logic [2:0]  dec_idx;
  logic        dec_legal;

  seq_state_t  state;
  phase_t      prev;
  logic [3:0]  lock_cnt;

  step_class_t step;
  logic [3:0]  lock_inc;
  logic        err_event;
  logic        wrap_event;

  johnson_decode u_decode (
    .code  (q_in),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  always_comb begin
    step     = classify_step(dec_legal, dec_idx, prev);
    lock_inc = lock_cnt + 4'd1;

    // Errors exist only once the monitor is tracking a sequence: an illegal
    // code while UNLOCKED is silently ignored.
    err_event = in_valid && (state != UNLOCKED) &&
                ((step == CL_BADSTEP) || (step == CL_ILLEGAL));

    // A successor landing on phase 0 can only have come from phase 7, so the
    // index alone identifies the ring wrap.
    wrap_event = in_valid && (state == LOCKED) &&
                 (step == CL_SUCC) && (dec_idx == 3'd0);
  end

  // -------------------------------------------------------------------------
  // FSM, lock counter, phase tracking, pulses and statistics counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= UNLOCKED;
      prev        <= '0;
      lock_cnt    <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      seq_error   <= 1'b0;
      wrap        <= 1'b0;
      err_count   <= '0;
      cycle_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side reads the pre-edge value regardless of statement order.
      seq_error <= err_event;
      wrap      <= wrap_event;

      if (err_event && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end

      if (wrap_event) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end

      if (in_valid) begin
        phase_valid <= dec_legal;

        // Phase history follows every legal code; illegal codes leave it as is.
        if (dec_legal) begin
          prev  <= dec_idx;
          phase <= dec_idx;
        end

        case (state)
          UNLOCKED: begin
            if (dec_legal) begin
              state    <= ACQUIRE;
              lock_cnt <= '0;
            end
          end

          ACQUIRE: begin
            case (step)
              CL_SUCC: begin
                lock_cnt <= lock_inc;
                if (lock_inc == LOCK_TARGET) begin
                  state <= LOCKED;
                end
              end
              CL_HOLD:    ;
              CL_BADSTEP: lock_cnt <= '0;
              CL_ILLEGAL: begin
                state    <= UNLOCKED;
                lock_cnt <= '0;
              end
              default:    ;
            endcase
          end

          LOCKED: begin
            case (step)
              CL_SUCC, CL_HOLD: ;
              CL_BADSTEP: begin
                state    <= ACQUIRE;
                lock_cnt <= '0;
              end
              CL_ILLEGAL: begin
                state    <= UNLOCKED;
                lock_cnt <= '0;
              end
              default:    ;
            endcase
          end

          default: begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule : johnson_seq_monitor

// File: tb/tb_johnson_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_monitor
//
// Two monitor instances share one stimulus stream: dut with default widths
// and dut_s with 2-bit error and cycle counters. Directed table rows carry
// hand-derived expectations for dut; every cycle both instances are also
// compared against a behavioural model of the lock/ring rules.
// ---------------------------------------------------------------------------
module tb_johnson_seq_monitor;

  localparam int L = 4;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] q_in;
  logic       in_valid;

  logic [2:0] phase,   phase_s;
  logic       pv,      pv_s;
  logic       locked,  locked_s;
  logic       serr,    serr_s;
  logic       wrap,    wrap_s;
  logic [7:0] errc,    cycc;
  logic [1:0] errc_s,  cycc_s;

  always #5 clock = ~clock;

  johnson_seq_monitor #(.LOCK_COUNT(L), .ERR_W(8), .CYC_W(8)) dut (
    .clock(clock), .clear(clear), .q_in(q_in), .in_valid(in_valid),
    .phase(phase), .phase_valid(pv), .locked(locked), .seq_error(serr),
    .wrap(wrap), .err_count(errc), .cycle_count(cycc)
  );

  johnson_seq_monitor #(.LOCK_COUNT(L), .ERR_W(2), .CYC_W(2)) dut_s (
    .clock(clock), .clear(clear), .q_in(q_in), .in_valid(in_valid),
    .phase(phase_s), .phase_valid(pv_s), .locked(locked_s), .seq_error(serr_s),
    .wrap(wrap_s), .err_count(errc_s), .cycle_count(cycc_s)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ----------------------------------------------------------- reference model
  // Ring codes by phase; the model finds an index by searching this list.
  logic [3:0] ring [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  bit tracking;   // a legal code has been seen since the last unlock/clear
  bit m_locked;
  int m_prev;
  int run;        // successors counted since (re)starting acquisition
  int errs;       // total error pulses since clear (unbounded)
  int wraps;      // total wrap pulses since clear (unbounded)
  int e_phase;
  bit e_pv, e_err, e_wrap;

  function automatic int lookup(input logic [3:0] code);
    for (int i = 0; i < 8; i++) if (ring[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    tracking = 0; m_locked = 0; m_prev = 0; run = 0;
    errs = 0; wraps = 0; e_phase = 0; e_pv = 0; e_err = 0; e_wrap = 0;
  endtask

  task automatic model_step(input logic clr, input logic vld, input logic [3:0] code);
    int idx;
    e_err  = 0;
    e_wrap = 0;
    if (clr) begin
      model_reset();
      return;
    end
    if (!vld) return;
    idx = lookup(code);
    if (idx < 0) begin
      e_pv = 0;
      if (tracking) e_err = 1;
      tracking = 0;
      m_locked = 0;
    end else begin
      e_pv = 1;
      if (!tracking) begin
        tracking = 1;
        run      = 0;
      end else if (idx == (m_prev + 1) % 8) begin
        if (m_locked) begin
          if (m_prev == 7) e_wrap = 1;
        end else begin
          run++;
          if (run == L) m_locked = 1;
        end
      end else if (idx != m_prev) begin
        e_err    = 1;
        m_locked = 0;
        run      = 0;
      end
      m_prev  = idx;
      e_phase = idx;
    end
    if (e_err)  errs++;
    if (e_wrap) wraps++;
  endtask

  task automatic compare_model();
    check("model.phase",        32'(phase),    32'(e_phase));
    check("model.phase_valid",  32'(pv),       32'(e_pv));
    check("model.locked",       32'(locked),   32'(m_locked));
    check("model.seq_error",    32'(serr),     32'(e_err));
    check("model.wrap",         32'(wrap),     32'(e_wrap));
    check("model.err_count",    32'(errc),     32'((errs > 255) ? 255 : errs));
    check("model.cycle_count",  32'(cycc),     32'(wraps % 256));
    check("model_s.phase",      32'(phase_s),  32'(e_phase));
    check("model_s.locked",     32'(locked_s), 32'(m_locked));
    check("model_s.seq_error",  32'(serr_s),   32'(e_err));
    check("model_s.wrap",       32'(wrap_s),   32'(e_wrap));
    check("model_s.err_count",  32'(errc_s),   32'((errs > 3) ? 3 : errs));
    check("model_s.cycle_count",32'(cycc_s),   32'(wraps % 4));
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic apply(input logic clr, input logic vld, input logic [3:0] code);
    @(negedge clock);
    clear    = clr;
    in_valid = vld;
    q_in     = code;
    @(posedge clock);
    #1;
    model_step(clr, vld, code);
    compare_model();
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic       clr;
    logic       vld;
    logic [3:0] code;
    logic [2:0] ph;
    logic       pv;
    logic       lk;
    logic       se;
    logic       wr;
    logic [7:0] ec;
    logic [7:0] cc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr, input logic vld, input logic [3:0] code,
                              input logic [2:0] ph, input logic pv, input logic lk,
                              input logic se, input logic wr,
                              input logic [7:0] ec, input logic [7:0] cc);
    vec_t v;
    v.clr = clr; v.vld = vld; v.code = code; v.ph = ph; v.pv = pv;
    v.lk = lk; v.se = se; v.wr = wr; v.ec = ec; v.cc = cc;
    return v;
  endfunction

  initial begin
    clear = 1'b1; in_valid = 1'b0; q_in = 4'b0000;
    model_reset();

    //                clr v  code     ph pv lk se wr ec cc
    // Reset, then a clean stream locks on the 5th sample.
    vecs.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0001, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0011, 2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0111, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 4, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1110, 5, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 6, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1000, 7, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 4'b0001, 1, 1, 1, 0, 0, 0, 1));
    // Illegal code while locked: error, unlock, phase held.
    vecs.push_back(mk(0, 1, 4'b0101, 1, 0, 0, 1, 0, 1, 1));
    // Legal code re-enters ACQUIRE; holds with 2-cycle gaps keep lock_cnt.
    vecs.push_back(mk(0, 1, 4'b0011, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'b1010, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'b1111, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b0111, 3, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 4, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b1110, 5, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b1100, 6, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b1000, 7, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 4'b0001, 1, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 4'b0011, 2, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 4'b0111, 3, 1, 1, 0, 0, 1, 2));
    // Bad step 3 -> 6 while locked; four successors relock, no wrap in ACQUIRE.
    vecs.push_back(mk(0, 1, 4'b1100, 6, 1, 0, 1, 0, 2, 2));
    vecs.push_back(mk(0, 1, 4'b1000, 7, 1, 0, 0, 0, 2, 2));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 0, 0, 0, 2, 2));
    vecs.push_back(mk(0, 1, 4'b0001, 1, 1, 0, 0, 0, 2, 2));
    vecs.push_back(mk(0, 1, 4'b0011, 2, 1, 1, 0, 0, 2, 2));
    // Illegal code with in_valid low is ignored.
    vecs.push_back(mk(0, 0, 4'b0101, 2, 1, 1, 0, 0, 2, 2));
    // Clear while locked with in_valid high wins.
    vecs.push_back(mk(1, 1, 4'b0111, 0, 0, 0, 0, 0, 0, 0));
    // Illegal while unlocked: no error.
    vecs.push_back(mk(0, 1, 4'b1010, 0, 0, 0, 0, 0, 0, 0));
    // Relock needs the full L+1 samples.
    vecs.push_back(mk(0, 1, 4'b0111, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 4, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1110, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 6, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1000, 7, 1, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].clr, vecs[i].vld, vecs[i].code);
      check($sformatf("vec%0d.phase", i),       32'(phase),  32'(vecs[i].ph));
      check($sformatf("vec%0d.phase_valid", i), 32'(pv),     32'(vecs[i].pv));
      check($sformatf("vec%0d.locked", i),      32'(locked), 32'(vecs[i].lk));
      check($sformatf("vec%0d.seq_error", i),   32'(serr),   32'(vecs[i].se));
      check($sformatf("vec%0d.wrap", i),        32'(wrap),   32'(vecs[i].wr));
      check($sformatf("vec%0d.err_count", i),   32'(errc),   32'(vecs[i].ec));
      check($sformatf("vec%0d.cycle_count", i), 32'(cycc),   32'(vecs[i].cc));
    end

    // Five bad steps from locked phase 7: 2-bit error counter stops at 3.
    apply(0, 1, 4'b0011);
    check("badstep.first_pulse", 32'(serr), 32'd1);
    apply(0, 1, 4'b1111);
    apply(0, 1, 4'b0000);
    apply(0, 1, 4'b0111);
    apply(0, 1, 4'b1110);
    check("sat.err_count_w2", 32'(errc_s), 32'd3);
    check("sat.err_count_w8", 32'(errc),   32'd5);
    check("sat.last_pulse",   32'(serr_s), 32'd1);

    // Five locked ring cycles: 2-bit cycle counter reads 5 mod 4 = 1.
    apply(1, 0, 4'b0000);
    for (int i = 0; i <= 40; i++) apply(0, 1, ring[i % 8]);
    check("cyc.cycle_count_w2", 32'(cycc_s), 32'd1);
    check("cyc.cycle_count_w8", 32'(cycc),   32'd5);
    check("cyc.err_count_w8",   32'(errc),   32'd0);

    // Randomised stream: mostly clean advances, with holds, gaps, stray codes
    // and the odd clear.
    begin
      int cur = 0;
      for (int n = 0; n < 3000; n++) begin
        int r = int'($urandom_range(0, 199));
        if (r < 140) begin
          cur = (cur + 1) % 8;
          apply(0, 1, ring[cur]);
        end else if (r < 160) begin
          apply(0, 1, ring[cur]);
        end else if (r < 180) begin
          apply(0, 1, 4'($urandom_range(0, 15)));
        end else if (r < 198) begin
          apply(0, 0, 4'($urandom_range(0, 15)));
        end else begin
          apply(1, r[0], ring[cur]);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_johnson_seq_monitor
